// File: rtl/rx_pkt_pkg.sv
// Shared types and width helpers for the packet deframer.
package rx_pkt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } rx_pkt_state_t;

  typedef enum logic [1:0] {
    ERR_CHK     = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } rx_pkt_err_t;

  // Buffer address width; a 1-entry buffer still needs a 1-bit address.
  function automatic int buf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rx_packet_ctrl_if.sv
// Byte input, packet handshake and buffer read bus of the deframer.
// slave = deframer side, master = receiver/command-decoder side.
interface rx_packet_ctrl_if #(
  parameter int MAX_LEN = 16
);
  import rx_pkt_pkg::*;

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = buf_aw(MAX_LEN);

  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_pkt_valid;
  logic          i_pkt_ready;
  logic [7:0]    o_pkt_cmd;
  logic [LW-1:0] o_pkt_len;
  logic [AW-1:0] i_rd_addr;
  logic [7:0]    o_rd_data;
  logic          o_err;
  logic [1:0]    o_err_code;

  modport slave (
    input  i_byte_valid, i_byte, i_pkt_ready, i_rd_addr,
    output o_pkt_valid, o_pkt_cmd, o_pkt_len, o_rd_data, o_err, o_err_code
  );

  modport master (
    output i_byte_valid, i_byte, i_pkt_ready, i_rd_addr,
    input  o_pkt_valid, o_pkt_cmd, o_pkt_len, o_rd_data, o_err, o_err_code
  );

endinterface

// File: rtl/rx_pkt_buf.sv
// Payload buffer: simple dual-port RAM, one write port, registered read port.
module rx_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Write port: contents survive reset on purpose, only a new frame overwrites.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port, data one cycle after the address.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_rdata <= 8'h00;
    else       o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/rx_packet_ctrl.sv
// Deframes SYNC,CMD,LEN,payload,CHK from the UART byte stream, buffers the
// payload and holds each good packet until the decoder accepts it.
module rx_packet_ctrl
  import rx_pkt_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 100000
) (
  input logic               i_clk,
  input logic               i_rst,
  rx_packet_ctrl_if.slave   bus
);

  localparam int         LW      = $clog2(MAX_LEN + 1);
  localparam int         AW      = buf_aw(MAX_LEN);
  localparam int         TW      = $clog2(TIMEOUT + 1);
  localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

  rx_pkt_state_t r_state;
  logic [7:0]    r_cmd;
  logic [LW-1:0] r_len;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_chk;
  logic [TW-1:0] r_tmo;
  logic          r_pkt_valid;
  logic          r_err;
  rx_pkt_err_t   r_err_code;

  logic          w_bv;
  logic          w_we;
  logic          w_last;

  assign w_bv   = bus.i_byte_valid;
  assign w_we   = w_bv && (r_state == S_PAYLOAD);
  assign w_last = (LW'(r_idx) == r_len - LW'(1));

  // Deframing FSM with checksum, inter-byte timeout and error/packet outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cmd       <= 8'h00;
      r_len       <= '0;
      r_idx       <= '0;
      r_chk       <= 8'h00;
      r_tmo       <= '0;
      r_pkt_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_CHK;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (w_bv && bus.i_byte == SYNC_BYTE) r_state <= S_CMD;
        end
        S_HOLD: begin
          // A byte here has nowhere to go; the held packet stays intact.
          if (w_bv) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_OVERRUN;
          end
          if (bus.i_pkt_ready) begin
            r_pkt_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          if (w_bv) begin
            // A byte on the expiry cycle wins over the timeout.
            r_tmo <= '0;
            case (r_state)
              S_CMD: begin
                r_cmd   <= bus.i_byte;
                r_chk   <= bus.i_byte;
                r_state <= S_LEN;
              end
              S_LEN: begin
                if ({1'b0, bus.i_byte} > MAX_LEN9) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_LEN;
                  r_state    <= S_IDLE;
                end else begin
                  r_len   <= LW'(bus.i_byte);
                  r_chk   <= r_chk ^ bus.i_byte;
                  r_idx   <= '0;
                  r_state <= (bus.i_byte == 8'h00) ? S_CHK : S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                r_chk <= r_chk ^ bus.i_byte;
                if (w_last) r_state <= S_CHK;
                else        r_idx   <= r_idx + AW'(1);
              end
              S_CHK: begin
                if (bus.i_byte == r_chk) begin
                  r_pkt_valid <= 1'b1;
                  r_state     <= S_HOLD;
                end else begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_CHK;
                  r_state    <= S_IDLE;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            // This idle cycle brings the count to TIMEOUT.
            r_tmo      <= '0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_state    <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
      endcase
    end
  end

  rx_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (bus.i_byte),
    .i_raddr (bus.i_rd_addr),
    .o_rdata (bus.o_rd_data)
  );

  assign bus.o_pkt_valid = r_pkt_valid;
  assign bus.o_pkt_cmd   = r_cmd;
  assign bus.o_pkt_len   = r_len;
  assign bus.o_err       = r_err;
  assign bus.o_err_code  = r_err_code;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Bench for rx_packet_ctrl: frame table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_rx_packet_ctrl;
  import rx_pkt_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 50;
  localparam int AW      = $clog2(MAX_LEN);

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  rx_packet_ctrl_if #(.MAX_LEN(MAX_LEN)) bus();

  rx_packet_ctrl #(
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (MAX_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Monitor: counts error pulses and valid cycles, sampled away from the edge.
  int         err_total = 0;
  int         pv_total  = 0;
  logic [1:0] last_code = 2'd0;
  always @(negedge i_clk) begin
    if (bus.o_err === 1'b1) begin
      err_total = err_total + 1;
      last_code = bus.o_err_code;
    end
    if (bus.o_pkt_valid === 1'b1) pv_total = pv_total + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    @(posedge i_clk); #1;
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic accept();
    bus.i_pkt_ready = 1'b1;
    @(posedge i_clk); #1;
    bus.i_pkt_ready = 1'b0;
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    bus.i_rd_addr = AW'(a);
    @(posedge i_clk); #1;
    d = bus.o_rd_data;
  endtask

  task automatic send_nominal();
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h72);
  endtask

  typedef struct {
    int         n;
    logic [63:0] bytes;
    logic       vld;
    logic [7:0] cmd;
    logic [4:0] len;
    logic [7:0] p0;
    int         nerr;
    logic [1:0] code;
  } vec_t;

  vec_t       tbl[5];
  int         e0, p0;
  logic [7:0] d, cmd, x, sum;
  logic [7:0] pl[$];
  int         len;
  bit         bad, ovr;
  int         exp_err;

  initial begin
    tbl[0] = '{6, 64'hA5_12_02_34_56_72_00_00, 1'b1, 8'h12, 5'd2, 8'h34, 0, 2'd0};
    tbl[1] = '{6, 64'h00_FF_A5_07_00_07_00_00, 1'b1, 8'h07, 5'd0, 8'h00, 0, 2'd0};
    tbl[2] = '{6, 64'hA5_12_02_34_56_73_00_00, 1'b0, 8'h00, 5'd0, 8'h00, 1, 2'd0};
    tbl[3] = '{5, 64'hA5_20_01_AB_8A_00_00_00, 1'b1, 8'h20, 5'd1, 8'hAB, 0, 2'd0};
    tbl[4] = '{3, 64'hA5_01_11_00_00_00_00_00, 1'b0, 8'h00, 5'd0, 8'h00, 1, 2'd1};

    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    bus.i_pkt_ready  = 1'b0;
    bus.i_rd_addr    = '0;
    i_rst            = 1'b1;
    idle(3);
    chk("rst_valid", 32'(bus.o_pkt_valid), 32'd0);
    chk("rst_cmd",   32'(bus.o_pkt_cmd),   32'd0);
    chk("rst_len",   32'(bus.o_pkt_len),   32'd0);
    chk("rst_err",   32'(bus.o_err),       32'd0);
    chk("rst_code",  32'(bus.o_err_code),  32'd0);
    chk("rst_rd",    32'(bus.o_rd_data),   32'd0);
    i_rst = 1'b0;
    idle(2);

    // Table of whole frames.
    for (int v = 0; v < 5; v++) begin
      e0 = err_total; p0 = pv_total;
      for (int i = 0; i < tbl[v].n; i++) send_byte(tbl[v].bytes[63-8*i -: 8]);
      chk($sformatf("t%0d_valid", v), 32'(bus.o_pkt_valid), 32'(tbl[v].vld));
      if (tbl[v].nerr != 0) begin
        chk($sformatf("t%0d_errpulse", v), 32'(bus.o_err), 32'd1);
        chk($sformatf("t%0d_errcode", v), 32'(bus.o_err_code), 32'(tbl[v].code));
      end
      if (tbl[v].vld) begin
        chk($sformatf("t%0d_cmd", v), 32'(bus.o_pkt_cmd), 32'(tbl[v].cmd));
        chk($sformatf("t%0d_len", v), 32'(bus.o_pkt_len), 32'(tbl[v].len));
        if (tbl[v].len != 0) begin
          rd(0, d);
          chk($sformatf("t%0d_rd0", v), 32'(d), 32'(tbl[v].p0));
        end
        accept();
        chk($sformatf("t%0d_drop", v), 32'(bus.o_pkt_valid), 32'd0);
      end
      idle(1);
      chk($sformatf("t%0d_errcnt", v), 32'(err_total - e0), 32'(tbl[v].nerr));
      if (!tbl[v].vld) chk($sformatf("t%0d_novalid", v), 32'(pv_total - p0), 32'd0);
    end

    // Timeout fires exactly when the idle count reaches TIMEOUT.
    e0 = err_total;
    send_byte(8'hA5); send_byte(8'h01);
    idle(TIMEOUT - 1);
    chk("tmo_early", 32'(err_total - e0), 32'd0);
    idle(1);
    chk("tmo_pulse", 32'(bus.o_err), 32'd1);
    chk("tmo_code",  32'(bus.o_err_code), 32'd2);
    idle(1);
    chk("tmo_width", 32'(err_total - e0), 32'd1);
    send_byte(8'h01);                       // non-sync: discarded in IDLE
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h03);
    chk("tmo_idle_valid", 32'(bus.o_pkt_valid), 32'd1);
    chk("tmo_idle_cmd",   32'(bus.o_pkt_cmd),   32'h03);
    accept();

    // Byte on the expiry cycle wins; timeout is inactive in HOLD.
    e0 = err_total;
    send_byte(8'hA5); send_byte(8'h01);
    idle(TIMEOUT - 1);
    send_byte(8'h00);
    chk("tmo_race_err", 32'(bus.o_err), 32'd0);
    send_byte(8'h01);
    chk("tmo_race_valid", 32'(bus.o_pkt_valid), 32'd1);
    chk("tmo_race_len",   32'(bus.o_pkt_len),   32'd0);
    idle(TIMEOUT + 10);
    chk("hold_notmo_valid", 32'(bus.o_pkt_valid), 32'd1);
    chk("hold_notmo_err",   32'(err_total - e0), 32'd0);
    accept();

    // Overrun while holding.
    e0 = err_total;
    send_nominal();
    send_byte(8'h99);
    chk("ovr_pulse", 32'(bus.o_err), 32'd1);
    chk("ovr_code",  32'(bus.o_err_code), 32'd3);
    chk("ovr_valid", 32'(bus.o_pkt_valid), 32'd1);
    chk("ovr_cmd",   32'(bus.o_pkt_cmd), 32'h12);
    chk("ovr_len",   32'(bus.o_pkt_len), 32'd2);
    rd(0, d); chk("ovr_rd0", 32'(d), 32'h34);
    rd(1, d); chk("ovr_rd1", 32'(d), 32'h56);
    accept();
    chk("ovr_drop", 32'(bus.o_pkt_valid), 32'd0);
    idle(1);
    chk("ovr_errcnt", 32'(err_total - e0), 32'd1);

    // Reset mid-frame.
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h02); send_byte(8'h34);
    bus.i_rd_addr = '0;
    e0 = err_total;
    i_rst = 1'b1;
    idle(1);
    chk("mrst_valid", 32'(bus.o_pkt_valid), 32'd0);
    chk("mrst_cmd",   32'(bus.o_pkt_cmd),   32'd0);
    chk("mrst_len",   32'(bus.o_pkt_len),   32'd0);
    chk("mrst_rd",    32'(bus.o_rd_data),   32'd0);
    i_rst = 1'b0;
    idle(2);
    chk("mrst_noerr", 32'(err_total - e0), 32'd0);
    send_nominal();
    chk("mrst_valid2", 32'(bus.o_pkt_valid), 32'd1);
    chk("mrst_cmd2",   32'(bus.o_pkt_cmd),   32'h12);
    chk("mrst_len2",   32'(bus.o_pkt_len),   32'd2);
    rd(1, d); chk("mrst_rd1", 32'(d), 32'h56);
    accept();

    // Randomized frames against the frame-level model.
    for (int it = 0; it < 40; it++) begin
      len = (it == 0) ? MAX_LEN : (it == 1) ? MAX_LEN + 1 : $urandom_range(0, MAX_LEN + 2);
      cmd = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      ovr = ($urandom_range(0, 4) == 0);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      e0 = err_total; p0 = pv_total; exp_err = 0;

      repeat ($urandom_range(0, 2)) begin
        do x = 8'($urandom); while (x == 8'hA5);
        send_byte(x);
        idle($urandom_range(0, 3));
      end
      send_byte(8'hA5); idle($urandom_range(0, 3));
      send_byte(cmd);   idle($urandom_range(0, 3));
      send_byte(8'(len));
      if (len > MAX_LEN) begin
        exp_err = 1;
        chk("rnd_len_pulse", 32'(bus.o_err), 32'd1);
        chk("rnd_len_code",  32'(bus.o_err_code), 32'd1);
      end else begin
        sum = cmd ^ 8'(len);
        foreach (pl[i]) begin
          idle($urandom_range(0, 3));
          send_byte(pl[i]);
          sum = sum ^ pl[i];
        end
        idle($urandom_range(0, 3));
        send_byte(bad ? (sum ^ 8'($urandom_range(1, 255))) : sum);
        if (bad) begin
          exp_err = 1;
          chk("rnd_chk_pulse", 32'(bus.o_err), 32'd1);
          chk("rnd_chk_code",  32'(bus.o_err_code), 32'd0);
          chk("rnd_chk_novalid", 32'(bus.o_pkt_valid), 32'd0);
        end else begin
          chk("rnd_valid", 32'(bus.o_pkt_valid), 32'd1);
          chk("rnd_cmd",   32'(bus.o_pkt_cmd),   32'(cmd));
          chk("rnd_len",   32'(bus.o_pkt_len),   32'(len));
          foreach (pl[i]) begin
            rd(i, d);
            chk($sformatf("rnd_rd%0d", i), 32'(d), 32'(pl[i]));
          end
          if (ovr) begin
            exp_err = 1;
            send_byte(8'($urandom));
            chk("rnd_ovr_code",  32'(bus.o_err_code), 32'd3);
            chk("rnd_ovr_cmd",   32'(bus.o_pkt_cmd),  32'(cmd));
          end
          idle($urandom_range(0, 3));
          chk("rnd_hold", 32'(bus.o_pkt_valid), 32'd1);
          accept();
          chk("rnd_drop", 32'(bus.o_pkt_valid), 32'd0);
        end
      end
      idle(1);
      chk("rnd_errcnt", 32'(err_total - e0), 32'(exp_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
